// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the MEM-stage data memory access controller:
//   - default geometry (data width, address width, valid depth)
//   - loader starvation threshold
//   - sequencer state encoding
//   - address range check helper
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam int DMEM_DATA_W     = 16;
    localparam int DMEM_ADDR_W     = 6;
    localparam int DMEM_DEPTH      = 51;
    localparam int DMEM_STARVE_MAX = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_P_PRI = 3'd1,
        ST_P_WB  = 3'd2,
        ST_P_RSP = 3'd3,
        ST_L_ACC = 3'd4,
        ST_L_RSP = 3'd5
    } dmem_state_e;

    // True when the word address lies inside the populated part of the memory.
    function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/dmem_starve_ctr.sv
// ---------------------------------------------------------------------------
// dmem_starve_ctr
// Saturating wait counter used to protect the loader from starvation.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   inc_i  in  count one waiting cycle
//   clr_i  in  clear (has priority over inc_i)
//   sat_o  out counter has reached MAX
// ---------------------------------------------------------------------------
module dmem_starve_ctr #(
    parameter int MAX   = 4,
    parameter int CNT_W = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise increment until saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + ONE_C;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == MAX_C);

endmodule

// File: rtl/dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl
// Sequencer/arbiter for the single-port data memory of the MEM stage.
// A pipeline load/store becomes a primary access plus an optional base
// writeback read, with the pipeline stalled meanwhile. A loader/debug
// requester shares the port and is protected from starvation.
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   ls_valid/load/wb/addr/wb_addr/wdata   pipeline request (held until done)
//   ls_stall, ls_done, ls_rdata, ls_wb_data, ls_err   pipeline response
//   ld_req/we/addr/wdata            loader request (held until grant)
//   ld_gnt, ld_rvalid, ld_rdata     loader response
//   mem_en/we/addr/wdata, mem_rdata memory port (read data one cycle late)
// ---------------------------------------------------------------------------
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DEPTH      = DMEM_DEPTH,
    parameter int STARVE_MAX = DMEM_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ls_valid,
    input  logic              ls_load,
    input  logic              ls_wb,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [ADDR_W-1:0] ls_wb_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_stall,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [DATA_W-1:0] ls_wb_data,
    output logic              ls_err,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    dmem_state_e state_q;
    dmem_state_e state_d;

    // Request latched on the accept edge; loader requests reuse the primary fields.
    logic [ADDR_W-1:0] req_addr_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic              req_we_q;
    logic              req_wb_q;

    logic              ls_done_q;
    logic              ls_err_q;
    logic [DATA_W-1:0] ls_rdata_q;
    logic [DATA_W-1:0] ls_wb_data_q;

    logic pri_ok;
    logic wb_ok;
    logic pipe_req;
    logic ld_wins;
    logic pipe_win;
    logic starve_sat;
    logic starve_inc;
    logic starve_clr;

    assign pri_ok = addr_in_range(32'(req_addr_q), DEPTH);
    assign wb_ok  = addr_in_range(32'(wb_addr_q), DEPTH);

    // ls_valid is still high during the done cycle; that is the finished
    // request, not a new one.
    assign pipe_req = ls_valid & ~ls_done_q;
    assign ld_wins  = ld_req & starve_sat;
    assign pipe_win = pipe_req & ~ld_wins;

    assign starve_inc = ld_req & ~ld_gnt;
    assign starve_clr = (state_q == ST_L_ACC);

    dmem_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk   (clk),
        .rst_n (reset),
        .inc_i (starve_inc),
        .clr_i (starve_clr),
        .sat_o (starve_sat)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pipe_win) begin
                    state_d = ST_P_PRI;
                end else if (ld_req) begin
                    state_d = ST_L_ACC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_P_PRI: begin
                if (req_wb_q) begin
                    state_d = ST_P_WB;
                end else begin
                    state_d = ST_P_RSP;
                end
            end
            ST_P_WB:  state_d = ST_P_RSP;
            ST_P_RSP: state_d = ST_IDLE;
            ST_L_ACC: state_d = ST_L_RSP;
            ST_L_RSP: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Request capture on the accept edge; ignored while busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_addr_q  <= '0;
            wb_addr_q   <= '0;
            req_wdata_q <= '0;
            req_we_q    <= 1'b0;
            req_wb_q    <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (pipe_win) begin
                req_addr_q  <= ls_addr;
                wb_addr_q   <= ls_wb_addr;
                req_wdata_q <= ls_wdata;
                req_we_q    <= ~ls_load;
                req_wb_q    <= ls_wb;
            end else if (ld_req) begin
                req_addr_q  <= ld_addr;
                wb_addr_q   <= '0;
                req_wdata_q <= ld_wdata;
                req_we_q    <= ld_we;
                req_wb_q    <= 1'b0;
            end
        end
    end

    // Memory port and loader handshake decoded from state; a reset drops
    // the state to IDLE and so removes any strobe immediately.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ld_gnt    = 1'b0;
        ld_rvalid = 1'b0;
        ld_rdata  = '0;
        case (state_q)
            ST_P_PRI, ST_L_ACC: begin
                ld_gnt    = (state_q == ST_L_ACC);
                mem_en    = pri_ok;
                mem_we    = pri_ok & req_we_q;
                mem_addr  = req_addr_q;
                mem_wdata = req_wdata_q;
            end
            ST_P_WB: begin
                mem_en   = wb_ok;
                mem_addr = wb_addr_q;
            end
            ST_L_RSP: begin
                if (!req_we_q) begin
                    ld_rvalid = 1'b1;
                    ld_rdata  = pri_ok ? mem_rdata : '0;
                end else begin
                    ld_rvalid = 1'b0;
                    ld_rdata  = '0;
                end
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    // Pipeline response registers: read data capture, done and error pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ls_done_q    <= 1'b0;
            ls_err_q     <= 1'b0;
            ls_rdata_q   <= '0;
            ls_wb_data_q <= '0;
        end else begin
            ls_done_q <= 1'b0;
            ls_err_q  <= 1'b0;
            case (state_q)
                ST_P_WB: begin
                    if (!req_we_q) begin
                        ls_rdata_q <= pri_ok ? mem_rdata : '0;
                    end
                end
                ST_P_RSP: begin
                    ls_done_q <= 1'b1;
                    ls_err_q  <= ~pri_ok | (req_wb_q & ~wb_ok);
                    if (req_wb_q) begin
                        ls_wb_data_q <= wb_ok ? mem_rdata : '0;
                    end else if (!req_we_q) begin
                        ls_rdata_q <= pri_ok ? mem_rdata : '0;
                    end
                end
                default: begin
                    ls_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Stall gated by reset so every output reads zero while reset is held.
    assign ls_stall   = reset & ls_valid & ~ls_done_q;
    assign ls_done    = ls_done_q;
    assign ls_err     = ls_err_q;
    assign ls_rdata   = ls_rdata_q;
    assign ls_wb_data = ls_wb_data_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        ls_valid, ls_load, ls_wb;
    logic [5:0]  ls_addr, ls_wb_addr;
    logic [15:0] ls_wdata;
    logic        ls_stall, ls_done, ls_err;
    logic [15:0] ls_rdata, ls_wb_data;
    logic        ld_req, ld_we;
    logic [5:0]  ld_addr;
    logic [15:0] ld_wdata;
    logic        ld_gnt, ld_rvalid;
    logic [15:0] ld_rdata;
    logic        mem_en, mem_we;
    logic [5:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic        tb_init;
    logic [15:0] mem [0:63];

    int passed = 0;
    int total  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .ls_valid   (ls_valid),
        .ls_load    (ls_load),
        .ls_wb      (ls_wb),
        .ls_addr    (ls_addr),
        .ls_wb_addr (ls_wb_addr),
        .ls_wdata   (ls_wdata),
        .ls_stall   (ls_stall),
        .ls_done    (ls_done),
        .ls_rdata   (ls_rdata),
        .ls_wb_data (ls_wb_data),
        .ls_err     (ls_err),
        .ld_req     (ld_req),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_gnt     (ld_gnt),
        .ld_rvalid  (ld_rvalid),
        .ld_rdata   (ld_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Single-port synchronous memory: pattern A000|addr, word 5 = BEEF.
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 16'hA000 | 16'(i);
            mem[5]    <= 16'hBEEF;
            mem_rdata <= 16'h0000;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_ctl"}, 32'({ls_stall, ls_done, ls_err, ld_gnt, ld_rvalid, mem_en, mem_we, mem_addr}), 32'd0);
        chk({tag, "_lsdata"}, {ls_rdata, ls_wb_data}, 32'd0);
        chk({tag, "_lddata"}, {ld_rdata, mem_wdata}, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One pipeline op: returns latency (0 = timed out), mem_en/mem_we/stall
    // histories (shifted in, oldest at the top), response snapshot at done and
    // done|err one cycle later.
    task automatic pipe_op(input logic load, input logic wb, input logic [5:0] a,
                           input logic [5:0] wa, input logic [15:0] wd,
                           output int lat, output logic [7:0] en_h, output logic [7:0] we_h,
                           output logic [7:0] st_h, output logic [15:0] rd,
                           output logic [15:0] wbd, output logic err, output logic post);
        ls_valid = 1'b1; ls_load = load; ls_wb = wb;
        ls_addr = a; ls_wb_addr = wa; ls_wdata = wd;
        lat = 0; en_h = 8'h00; we_h = 8'h00; st_h = 8'h00;
        rd = 16'h0000; wbd = 16'h0000; err = 1'b0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            tick();
            en_h = {en_h[6:0], mem_en};
            we_h = {we_h[6:0], mem_we};
            st_h = {st_h[6:0], ls_stall};
            if (ls_done) begin
                lat = c; rd = ls_rdata; wbd = ls_wb_data; err = ls_err;
            end
        end
        ls_valid = 1'b0;
        tick();
        post = ls_done | ls_err;
    endtask

    task automatic ld_op(input logic we, input logic [5:0] a, input logic [15:0] wd,
                         output int gnt_c, output int rv_c, output logic [15:0] rd,
                         output logic en_g, output logic we_g);
        ld_req = 1'b1; ld_we = we; ld_addr = a; ld_wdata = wd;
        gnt_c = 0; rv_c = 0; rd = 16'h0000; en_g = 1'b0; we_g = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (ld_gnt) begin
                gnt_c = c; en_g = mem_en; we_g = mem_we; ld_req = 1'b0;
            end
            if (ld_rvalid) begin
                rv_c = c; rd = ld_rdata;
            end
        end
        ld_req = 1'b0;
    endtask

    int          lat, gnt_c, rv_c, dones, gnt_dones, gnt_seen, bad;
    logic [7:0]  en_h, we_h, st_h;
    logic [15:0] rd, wbd, ldrd;
    logic        err, post, en_g, we_g, seen_done;

    initial begin
        ls_valid = 1'b0; ls_load = 1'b0; ls_wb = 1'b0; ls_addr = 6'd0;
        ls_wb_addr = 6'd0; ls_wdata = 16'h0000;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = 6'd0; ld_wdata = 16'h0000;
        tb_init = 1'b1;
        reset = 1'b0;
        #1;
        chk_outs_zero("reset_async");
        repeat (3) tick();
        chk_outs_zero("reset_held");
        tb_init = 1'b0;
        reset = 1'b1;
        tick();

        // Plain load of word 5.
        pipe_op(1'b1, 1'b0, 6'd5, 6'd0, 16'h0000, lat, en_h, we_h, st_h, rd, wbd, err, post);
        chk("ld5_latency", 32'(lat), 32'd3);
        chk("ld5_rdata", 32'(rd), 32'h0000BEEF);
        chk("ld5_err", 32'(err), 32'd0);
        chk("ld5_mem_en_hist", 32'(en_h), 32'h04);
        chk("ld5_stall_hist", 32'(st_h), 32'h06);
        chk("ld5_done_pulse", 32'(post), 32'd0);

        // Load with base writeback.
        pipe_op(1'b1, 1'b1, 6'd3, 6'd7, 16'h0000, lat, en_h, we_h, st_h, rd, wbd, err, post);
        chk("ldwb_latency", 32'(lat), 32'd4);
        chk("ldwb_rdata", 32'(rd), 32'h0000A003);
        chk("ldwb_wb_data", 32'(wbd), 32'h0000A007);
        chk("ldwb_mem_en_hist", 32'(en_h), 32'h0C);
        chk("ldwb_we_hist", 32'(we_h), 32'h00);

        // Store with writeback to the same address sees the new word.
        pipe_op(1'b0, 1'b1, 6'd10, 6'd10, 16'h1234, lat, en_h, we_h, st_h, rd, wbd, err, post);
        chk("stwb_latency", 32'(lat), 32'd4);
        chk("stwb_we_hist", 32'(we_h), 32'h08);
        chk("stwb_wb_data", 32'(wbd), 32'h00001234);

        // Out-of-range load.
        pipe_op(1'b1, 1'b0, 6'd60, 6'd0, 16'h0000, lat, en_h, we_h, st_h, rd, wbd, err, post);
        chk("oor_latency", 32'(lat), 32'd3);
        chk("oor_mem_en_hist", 32'(en_h), 32'h00);
        chk("oor_rdata", 32'(rd), 32'd0);
        chk("oor_err", 32'(err), 32'd1);
        chk("oor_err_pulse", 32'(post), 32'd0);

        // Loader read, write, dropped out-of-range write, out-of-range read.
        ld_op(1'b0, 6'd10, 16'h0000, gnt_c, rv_c, rd, en_g, we_g);
        chk("ldr_gnt_cycle", 32'(gnt_c), 32'd1);
        chk("ldr_rvalid_cycle", 32'(rv_c), 32'd2);
        chk("ldr_rdata", 32'(rd), 32'h00001234);
        ld_op(1'b1, 6'd20, 16'h5555, gnt_c, rv_c, rd, en_g, we_g);
        chk("ldw_gnt_cycle", 32'(gnt_c), 32'd1);
        chk("ldw_no_rvalid", 32'(rv_c), 32'd0);
        chk("ldw_mem_en_we", 32'({en_g, we_g}), 32'd3);
        pipe_op(1'b1, 1'b0, 6'd20, 6'd0, 16'h0000, lat, en_h, we_h, st_h, rd, wbd, err, post);
        chk("ldw_readback", 32'(rd), 32'h00005555);
        ld_op(1'b1, 6'd55, 16'h7777, gnt_c, rv_c, rd, en_g, we_g);
        chk("ldw_oor_gnt_cycle", 32'(gnt_c), 32'd1);
        chk("ldw_oor_dropped", 32'({en_g, we_g}), 32'd0);
        ld_op(1'b0, 6'd60, 16'h0000, gnt_c, rv_c, rd, en_g, we_g);
        chk("ldr_oor_rvalid_cycle", 32'(rv_c), 32'd2);
        chk("ldr_oor_rdata", 32'(rd), 32'd0);

        // Loader held against a continuously requesting pipeline.
        ls_valid = 1'b1; ls_load = 1'b1; ls_wb = 1'b0; ls_addr = 6'd3;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 6'd5;
        dones = 0; gnt_dones = -1; gnt_seen = 0; bad = 0; ldrd = 16'h0000;
        for (int c = 1; c <= 60 && dones < 3; c++) begin
            tick();
            if (ld_gnt) begin
                gnt_dones = dones; gnt_seen++; ld_req = 1'b0;
            end
            if (ld_rvalid) ldrd = ld_rdata;
            if (ls_done) begin
                dones++;
                if (ls_rdata !== 16'hA003) bad++;
                if (dones == 3) ls_valid = 1'b0;
            end
        end
        tick();
        chk("starve_pipe_dones", 32'(dones), 32'd3);
        chk("starve_gnt_count", 32'(gnt_seen), 32'd1);
        chk("starve_gnt_bound", 32'((gnt_dones >= 1 && gnt_dones <= 4) ? 1 : 0), 32'd1);
        chk("starve_ld_rdata", 32'(ldrd), 32'h0000BEEF);
        chk("starve_pipe_rdata_bad", 32'(bad), 32'd0);

        // Reset asserted while the writeback read is on the port.
        ls_valid = 1'b1; ls_load = 1'b1; ls_wb = 1'b1; ls_addr = 6'd3; ls_wb_addr = 6'd7;
        tick();
        tick();
        chk("pwb_mem_en", 32'(mem_en), 32'd1);
        chk("pwb_mem_addr", 32'(mem_addr), 32'd7);
        #2;
        reset = 1'b0;
        #1;
        chk_outs_zero("reset_in_pwb");
        ls_valid = 1'b0; ls_wb = 1'b0;
        seen_done = 1'b0;
        repeat (2) begin
            tick();
            seen_done = seen_done | ls_done;
        end
        reset = 1'b1;
        repeat (3) begin
            tick();
            seen_done = seen_done | ls_done | ls_stall | mem_en;
        end
        chk("reset_abandons_op", 32'(seen_done), 32'd0);

        // Fresh request after reset.
        pipe_op(1'b1, 1'b0, 6'd7, 6'd0, 16'h0000, lat, en_h, we_h, st_h, rd, wbd, err, post);
        chk("post_rst_latency", 32'(lat), 32'd3);
        chk("post_rst_rdata", 32'(rd), 32'h0000A007);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
